// File: rtl/pixel_channel_feeder.sv
// Streams one delayed RF sample per receive channel into a DAS/DMAS beamformer core.
// Optional APOD_EN: per-channel aperture mask zeroes disabled channels.
module pixel_channel_feeder #(
  parameter int CHANNELS = 128,
  parameter int CH_W     = 7,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic signed [15:0]       wr_data,
  input  logic                     dly_we,
  input  logic [CH_W-1:0]          dly_ch,
  input  logic [7:0]               dly_val,
  input  logic                     apod_we,
  input  logic [CH_W-1:0]          apod_ch,
  input  logic                     apod_bit,
  input  logic                     start,
  input  logic                     mode_in,
  output logic                     core_rst,
  output logic                     mode_out,
  output logic signed [15:0]       chnl_data,
  output logic signed [1:0]        sign,
  output logic                     chnl_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int MEM_W = CH_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W:0]       ch_q, ch_d;
  logic                mode_q, mode_d;
  logic                valid_q, valid_d;
  logic                zero_q, zero_d;
  logic signed [15:0]  rd_data_q;

  logic signed [15:0]  sample_mem [0:CHANNELS*DEPTH-1];
  logic [7:0]          dly_q [0:CHANNELS-1];

  logic [CH_W-1:0]     rd_ch;
  logic [7:0]          rd_dly;
  logic [MEM_W-1:0]    rd_addr;
  logic                rd_issue;
  logic                rd_oow;
  logic                rd_masked;
  logic                tbl_we_ok;
  logic signed [15:0]  sample_sel;

  // The counter runs one step past the last channel so the final read can drain.
  assign rd_ch     = ch_q[CH_W-1:0];
  assign rd_dly    = dly_q[rd_ch];
  assign rd_addr   = {rd_ch, rd_dly[ADDR_W-1:0]};
  assign rd_issue  = (state_q == STREAM) && !ch_q[CH_W];
  assign rd_oow    = ({24'd0, rd_dly} >= DEPTH);
  assign tbl_we_ok = (state_q == IDLE);

`ifdef APOD_EN
  logic [CHANNELS-1:0] apod_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apod_q <= '1;
    end else if (apod_we && tbl_we_ok) begin
      apod_q[apod_ch] <= apod_bit;
    end
  end

  assign rd_masked = ~apod_q[rd_ch];
`else
  logic apod_unused;
  assign apod_unused = ^{apod_we, apod_ch, apod_bit};
  assign rd_masked   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        dly_q[i] <= 8'd0;
      end
    end else if (dly_we && tbl_we_ok) begin
      dly_q[dly_ch] <= dly_val;
    end
  end

  // Sample store survives reset; a colliding read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sample_mem[{wr_ch, wr_idx}] <= wr_data;
    end
    rd_data_q <= sample_mem[rd_addr];
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mode_d   = mode_q;
    valid_d  = rd_issue;
    zero_d   = rd_oow || rd_masked;
    core_rst = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = CLEAR;
          mode_d  = mode_in;
        end
      end
      CLEAR: begin
        core_rst = 1'b1;
        ch_d     = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        ch_d = ch_q + 1'b1;
        if (ch_q[CH_W]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign mode_out   = mode_q;
  assign chnl_valid = valid_q;

  // DMAS splits the sample into magnitude and sign; -32768 has no positive twin.
  always_comb begin
    sample_sel = zero_q ? 16'sd0 : rd_data_q;
    chnl_data  = 16'sd0;
    sign       = 2'sb01;
    if (valid_q) begin
      if (mode_q) begin
        chnl_data = sample_sel;
      end else if (sample_sel[15]) begin
        sign      = 2'sb11;
        chnl_data = (sample_sel == 16'sh8000) ? 16'sh7fff : -sample_sel;
      end else begin
        chnl_data = sample_sel;
      end
    end
  end

endmodule
